// File: rtl/fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_queue_pkg
// Shared constants and types for the instruction fetch queue.
//   RESET_PC   : PC fetched first after reset
//   FQ_DEPTH   : default number of buffered instruction entries
//   FQ_IADDR_W : default instruction-memory word-address width
//   INS_W      : instruction width
//   fq_entry_t : one queue entry (instruction word plus its word PC)
// ---------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FQ_DEPTH   = 4;
    localparam int          FQ_IADDR_W = 8;
    localparam int          INS_W      = 32;

    typedef struct packed {
        logic [INS_W-1:0] ins;
        logic [31:0]      pc;
    } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// ---------------------------------------------------------------------------
// fq_fifo
// Small FIFO holding fetched instructions with their PCs.
// Ports:
//   clk, rstd           : clock, asynchronous active-low reset
//   push, push_entry    : write one entry at the tail
//   pop                 : remove the head entry (ignored when empty)
//   flush               : drop all entries, pointers back to 0 (wins over push/pop)
//   count               : number of entries held (0..DEPTH)
//   head_entry          : head entry, combinational; reads 0 when empty
// ---------------------------------------------------------------------------
module fq_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rstd,
    input  logic                     push,
    input  fq_entry_t                push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output fq_entry_t                head_entry
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fq_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               push_ok;
    logic               pop_ok;

    // The issuer never over-commits, so push never meets a full queue;
    // pop is still qualified so an empty pop cannot corrupt the pointers.
    assign push_ok = push && !flush;
    assign pop_ok  = pop && !flush && (count_reg != '0);

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            count_next = count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset: the head is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    assign count      = count_reg;
    assign head_entry = (count_reg != '0) ? mem[rd_ptr_reg] : '0;

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Instruction prefetch queue between a one-cycle-latency instruction memory
// and the execute stage. Issues sequential reads while there is guaranteed
// room, buffers returned words in order and flushes/refetches on redirect.
// Ports:
//   clk, rstd              : clock, asynchronous active-low reset
//   imem_req, imem_addr    : memory read request and word address
//   imem_data              : read data, valid the cycle after imem_req
//   redirect, redirect_pc  : flush the queue and restart fetch at redirect_pc
//   ins, ins_pc, ins_valid : head instruction, its word PC, head present
//   ins_ready              : execute consumes the head when ins_valid=1
// ---------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH   = FQ_DEPTH,
    parameter int IADDR_W = FQ_IADDR_W
) (
    input  logic               clk,
    input  logic               rstd,
    output logic               imem_req,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic [INS_W-1:0]   imem_data,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [INS_W-1:0]   ins,
    output logic [31:0]        ins_pc,
    output logic               ins_valid,
    input  logic               ins_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      fetch_pc_reg;
    logic             pending_reg;
    logic [31:0]      pend_pc_reg;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occupancy;
    logic             push;
    logic             pop;
    fq_entry_t        push_entry;
    fq_entry_t        head_entry;

    // Entries already held plus the one in flight. Pop credit is deliberately
    // ignored so a returning word always has a free slot.
    assign occupancy = (CNT_W+1)'(count) + (CNT_W+1)'(pending_reg);

    // rstd gates the request so nothing is issued while reset is held.
    assign imem_req  = rstd && !redirect && (occupancy < (CNT_W+1)'(DEPTH));
    assign imem_addr = fetch_pc_reg[IADDR_W-1:0];

    // A response arriving in a redirect cycle belongs to the old stream.
    assign push       = pending_reg && !redirect;
    assign push_entry = '{ins: imem_data, pc: pend_pc_reg};
    assign pop        = ins_valid && ins_ready && !redirect;

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            fetch_pc_reg <= RESET_PC;
            pending_reg  <= 1'b0;
            pend_pc_reg  <= RESET_PC;
        end else begin
            // imem_req is already 0 on redirect, so pending clears as well.
            pending_reg <= imem_req;
            if (redirect) begin
                fetch_pc_reg <= redirect_pc;
            end else if (imem_req) begin
                fetch_pc_reg <= fetch_pc_reg + 32'd1;
                pend_pc_reg  <= fetch_pc_reg;
            end
        end
    end

    fq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstd       (rstd),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .head_entry (head_entry)
    );

    assign ins_valid = (count != '0);
    assign ins       = head_entry.ins;
    assign ins_pc    = head_entry.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Directed and random stimulus for fetch_queue. A memory model answers each
// request with word (address + 0x100); a scoreboard queue of expected PCs is
// rebuilt whenever a redirect or reset is driven and consumed on every pop.
// ---------------------------------------------------------------------------
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH   = 4;
    localparam int IADDR_W = 8;

    logic               clk = 1'b0;
    logic               rstd;
    logic               imem_req;
    logic [IADDR_W-1:0] imem_addr;
    logic [31:0]        imem_data = '0;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic [31:0]        ins;
    logic [31:0]        ins_pc;
    logic               ins_valid;
    logic               ins_ready;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb_q[$];
    logic [31:0] sb_next;

    fetch_queue #(
        .DEPTH   (DEPTH),
        .IADDR_W (IADDR_W)
    ) dut (
        .clk         (clk),
        .rstd        (rstd),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ins         (ins),
        .ins_pc      (ins_pc),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready)
    );

    always #5 clk = ~clk;

    // One-cycle-latency memory: word n holds n + 0x100; garbage when idle.
    always @(posedge clk) begin
        if (imem_req) imem_data <= 32'(imem_addr) + 32'h100;
        else          imem_data <= 32'hDEAD_0000;
    end

    function automatic logic [31:0] exp_ins(input logic [31:0] pc);
        return 32'(pc[IADDR_W-1:0]) + 32'h100;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_fill();
        while (sb_q.size() < 8) begin
            sb_q.push_back(sb_next);
            sb_next = sb_next + 32'd1;
        end
    endtask

    task automatic sb_reset(input logic [31:0] pc);
        sb_q.delete();
        sb_next = pc;
        sb_fill();
    endtask

    // Called at posedge+4: score any pop happening at the coming edge,
    // then advance to posedge+1 where the next inputs are driven.
    task automatic end_cycle();
        logic [31:0] exp_pc;
        check("count_le_depth", 32'(dut.count <= DEPTH), 32'd1);
        if (rstd && ins_valid && ins_ready && !redirect) begin
            exp_pc = sb_q.pop_front();
            sb_fill();
            check("ins_pc", ins_pc, exp_pc);
            check("ins", ins, exp_ins(exp_pc));
            $display("pop ins_pc=%h ins=%h", ins_pc, ins);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_cycle();
        #3;
        end_cycle();
    endtask

    initial begin
        rstd        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        ins_ready   = 1'b1;
        sb_reset(RESET_PC);

        // Reset held: outputs quiet and zero.
        repeat (2) @(posedge clk);
        #4;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_ins_valid", 32'(ins_valid), 32'd0);
        check("rst_ins", ins, 32'd0);
        check("rst_ins_pc", ins_pc, 32'd0);
        @(posedge clk);
        #1;

        // Release: request at 0 immediately, first instruction in cycle 2.
        rstd = 1'b1;
        sb_reset(RESET_PC);
        #3;
        check("c0_imem_req", 32'(imem_req), 32'd1);
        check("c0_imem_addr", 32'(imem_addr), 32'h00);
        check("c0_ins_valid", 32'(ins_valid), 32'd0);
        end_cycle();
        #3;
        check("c1_imem_addr", 32'(imem_addr), 32'h01);
        check("c1_ins_valid", 32'(ins_valid), 32'd0);
        end_cycle();
        #3;
        check("c2_ins_valid", 32'(ins_valid), 32'd1);
        check("c2_ins_pc", ins_pc, 32'd0);
        end_cycle();
        for (int i = 0; i < 6; i++) begin
            #3;
            check("steady_ins_valid", 32'(ins_valid), 32'd1);
            end_cycle();
        end

        // Back-pressure: queue fills to DEPTH and fetch stops.
        ins_ready = 1'b0;
        repeat (10) do_cycle();
        #3;
        check("full_imem_req", 32'(imem_req), 32'd0);
        check("full_count", 32'(dut.count), 32'(DEPTH));
        end_cycle();
        ins_ready = 1'b1;
        repeat (8) do_cycle();

        // Redirect with three entries held and one response in flight.
        ins_ready   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        sb_reset(32'h10);
        do_cycle();
        redirect = 1'b0;
        repeat (4) do_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        sb_reset(32'h40);
        #3;
        check("rd_pre_count", 32'(dut.count), 32'd3);
        check("rd_pre_pending", 32'(dut.pending_reg), 32'd1);
        check("rd_imem_req", 32'(imem_req), 32'd0);
        end_cycle();
        redirect = 1'b0;
        #3;
        check("rd_ins_valid", 32'(ins_valid), 32'd0);
        check("rd_imem_req_next", 32'(imem_req), 32'd1);
        check("rd_imem_addr", 32'(imem_addr), 32'h40);
        end_cycle();
        ins_ready = 1'b1;
        repeat (6) do_cycle();

        // Address wrap: imem_addr wraps, ins_pc keeps counting.
        redirect    = 1'b1;
        redirect_pc = 32'hFE;
        sb_reset(32'hFE);
        do_cycle();
        redirect = 1'b0;
        #3;
        check("wrap_addr0", 32'(imem_addr), 32'hFE);
        end_cycle();
        #3;
        check("wrap_addr1", 32'(imem_addr), 32'hFF);
        end_cycle();
        #3;
        check("wrap_addr2", 32'(imem_addr), 32'h00);
        end_cycle();
        repeat (5) do_cycle();

        // Reset pulse mid-stream with three entries queued.
        ins_ready   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        sb_reset(32'h20);
        do_cycle();
        redirect = 1'b0;
        repeat (4) do_cycle();
        #3;
        check("mid_count", 32'(dut.count), 32'd3);
        rstd = 1'b0;
        #1;
        check("mid_rst_ins_valid", 32'(ins_valid), 32'd0);
        check("mid_rst_imem_req", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        rstd      = 1'b1;
        ins_ready = 1'b1;
        sb_reset(RESET_PC);
        #3;
        check("rel_imem_addr", 32'(imem_addr), 32'h00);
        check("rel_imem_req", 32'(imem_req), 32'd1);
        end_cycle();
        do_cycle();
        #3;
        check("rel_ins_valid", 32'(ins_valid), 32'd1);
        check("rel_ins_pc", ins_pc, 32'd0);
        end_cycle();

        // Random ready and redirects.
        for (int i = 0; i < 1000; i++) begin
            ins_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) begin
                redirect    = 1'b1;
                redirect_pc = $urandom;
                sb_reset(redirect_pc);
            end else begin
                redirect = 1'b0;
            end
            do_cycle();
        end
        redirect = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction entries buffered (power of two, 2..16).
REQ-002 Parameter IADDR_W, default 8, instruction-memory word-address width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rstd  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  read request to instruction memory this cycle.
REQ-006 imem_addr  output  IADDR_W  word address of request; equals fetch_pc[IADDR_W-1:0].
REQ-007 imem_data  input  32  read data; valid exactly one cycle after the cycle imem_req was high.
REQ-008 redirect  input  1  execute-stage nextpc differs from sequential; flush and refetch.
REQ-009 redirect_pc  input  32  word-addressed target PC, sampled when redirect=1.
REQ-010 ins  output  32  instruction at queue head, to execute stage.
REQ-011 ins_pc  output  32  word PC of ins.
REQ-012 ins_valid  output  1  head entry present.
REQ-013 ins_ready  input  1  execute consumes head when ins_valid & ins_ready (pop).

Function
REQ-014 fetch_pc (32 bit) SHALL hold next address to request; increments by 1 per issued request.
REQ-015 imem_req SHALL be 1 iff redirect=0 and (count + pending) < DEPTH; pending = request issued previous cycle, not yet returned.
REQ-016 Returning imem_data SHALL be pushed with its PC at the posedge of the return cycle unless squashed.
REQ-017 Pop credit SHALL NOT be used for issue; overflow is therefore impossible; push and pop in the same cycle leave count unchanged.
REQ-018 ins_valid SHALL equal (count != 0); ins/ins_pc SHALL be combinational from head entry; undefined content when ins_valid=0 is don't-care.
REQ-019 Queue order SHALL be strict FIFO; read/write pointers wrap modulo DEPTH.
REQ-020 imem_addr SHALL wrap 2^IADDR_W-1 -> 0 while fetch_pc/ins_pc continue full 32-bit increment.
REQ-021 On redirect=1: at that posedge count<=0, pointers<=0, fetch_pc<=redirect_pc, any pending response squashed (not pushed next cycle); no request issued that cycle.
REQ-022 Redirect together with pop: redirect wins; pop has no further effect.
REQ-023 Redirect together with returning data: that data SHALL be discarded.
REQ-024 First request after redirect SHALL be issued the following cycle at redirect_pc; first valid ins two cycles after redirect.
REQ-025 Steady state with ins_ready=1 and no redirect: one instruction delivered per cycle after initial 2-cycle latency.

Reset
REQ-026 rstd=0 SHALL asynchronously set fetch_pc=0, count=0, pointers=0, pending=0.
REQ-027 During reset: imem_req=0, ins_valid=0; ins and ins_pc SHALL read 0.
REQ-028 First request (address 0) SHALL be issued in the first cycle with rstd=1; reset mid-operation discards all entries and any pending response.

Structure
REQ-029 Shared package/include file SHALL hold RESET_PC (0), default DEPTH, IADDR_W, and instruction width 32.
REQ-030 Storage and pointers SHALL be a sub-module fq_fifo (push, pop, flush, count, head data); issue/squash logic stays in fetch_queue.

Verification
REQ-031 Reset release, ins_ready=1, memory word n = n+0x100 -> ins 0x100,0x101,... one per cycle from cycle 2, ins_pc 0,1,2.
REQ-032 ins_ready=0 for 10 cycles -> exactly 4 entries held, imem_req drops to 0, no entry lost or duplicated after ready=1.
REQ-033 redirect=1, redirect_pc=0x40 while queue full and response pending -> next cycle ins_valid=0, imem_addr=0x40; next ins_pc=0x40, no stale instruction delivered.
REQ-034 redirect_pc=0xFE, ready=1 -> imem_addr 0xFE,0xFF,0x00; ins_pc 0xFE,0xFF,0x100.
REQ-035 rstd pulsed low mid-stream with 3 entries queued -> ins_valid=0 immediately; after release sequence restarts at ins_pc 0.
REQ-036 Random ins_ready (50%) over 1000 cycles with random redirects -> delivered ins_pc sequence matches reference model; count never exceeds DEPTH.
